// File: rtl/sc_pkg.sv
// Shared types and constants for the special-command pulse scheduler.
// Holds the FSM/pulse-type encodings, the grant priority order and the default widths.
package sc_pkg;

    localparam int DEF_DELAY_W   = 6;
    localparam int DEF_CAL_WIDTH = 8;
    localparam int DEF_HOLDOFF   = 4;
    localparam int DEF_PERIOD_W  = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } sched_state_t;

    typedef enum logic [1:0] {
        PT_NONE = 2'd0,
        PT_CAL  = 2'd1,
        PT_DTP  = 2'd2,
        PT_HPR  = 2'd3
    } pulse_type_t;

    // Highest priority sits in the most significant slot.
    localparam logic [5:0] PRIO_ORDER = {PT_HPR, PT_CAL, PT_DTP};

    // Bit position of each type in the {hpr, dtp, cal} request/ovf vectors.
    function automatic logic [1:0] type_bit(input pulse_type_t t);
        case (t)
            PT_DTP:  type_bit = 2'd1;
            PT_HPR:  type_bit = 2'd2;
            default: type_bit = 2'd0;
        endcase
    endfunction

    function automatic pulse_type_t pick_winner(input logic [2:0] pend);
        pulse_type_t cand;
        pick_winner = PT_NONE;
        for (int i = 2; i >= 0; i--) begin
            cand = pulse_type_t'(PRIO_ORDER[2*i +: 2]);
            if (pick_winner == PT_NONE && pend[type_bit(cand)]) begin
                pick_winner = cand;
            end
        end
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sc_req_latch.sv
// Pending bit plus sticky drop flag for one request type.
module sc_req_latch (
    input  logic bclk,
    input  logic rstb,
    input  logic strobe,
    input  logic clr,
    input  logic ovf_clr,
    output logic pending,
    output logic ovf
);

    logic drop;

    // A strobe landing on the grant that clears the bit simply re-arms it.
    assign drop = strobe && pending && !clr;

    always_ff @(posedge bclk) begin
        if (!rstb) begin
            pending <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (strobe) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sc_pulse_sched.sv
// Special-command pulse scheduler: latches requests, grants by priority, delays, shapes and holds off.
// Define SC_PERIODIC_HPR_EN to add the internal periodic HPR-clear timer.
module sc_pulse_sched
    import sc_pkg::*;
#(
    parameter int DELAY_W   = DEF_DELAY_W,
    parameter int CAL_WIDTH = DEF_CAL_WIDTH,
    parameter int HOLDOFF   = DEF_HOLDOFF,
    parameter int PERIOD_W  = DEF_PERIOD_W
) (
    input  logic                bclk,
    input  logic                rstb,
    input  logic                sched_en,
    input  logic [DELAY_W-1:0]  cfg_delay,
    input  logic [PERIOD_W-1:0] cfg_hpr_period,
    input  logic                req_cal,
    input  logic                req_dtp,
    input  logic                req_hpr,
    input  logic                ovf_clr,
    output logic                cal_pulse,
    output logic                dtp_pulse,
    output logic                hpr_clear,
    output logic                busy,
    output logic [2:0]          ovf
);

    localparam int CNT_W = max3(DELAY_W, $clog2(CAL_WIDTH + 1), $clog2(HOLDOFF + 1));
    localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_WIDTH - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

    sched_state_t     state, state_next;
    pulse_type_t      cur_type, type_next, winner;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             grant, hpr_tick;
    logic [2:0]       req_vec, pending, grant_clr;

`ifdef SC_PERIODIC_HPR_EN
    logic [PERIOD_W-1:0] period_cnt;

    // ">=" keeps the counter from running past a period that was lowered on the fly.
    assign hpr_tick = (cfg_hpr_period != '0) &&
                      (period_cnt >= cfg_hpr_period - PERIOD_W'(1));

    always_ff @(posedge bclk) begin
        if (!rstb || cfg_hpr_period == '0 || hpr_tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + PERIOD_W'(1);
        end
    end
`else
    logic unused_period;
    assign unused_period = ^cfg_hpr_period;
    assign hpr_tick      = 1'b0;
`endif

    assign req_vec = {req_hpr | hpr_tick, req_dtp, req_cal};

    for (genvar g = 0; g < 3; g++) begin : g_latch
        sc_req_latch u_latch (
            .bclk    (bclk),
            .rstb    (rstb),
            .strobe  (req_vec[g]),
            .clr     (grant_clr[g]),
            .ovf_clr (ovf_clr),
            .pending (pending[g]),
            .ovf     (ovf[g])
        );
    end

    always_comb begin
        state_next = state;
        type_next  = cur_type;
        cnt_next   = cnt;
        grant      = 1'b0;
        grant_clr  = '0;
        winner     = pick_winner(pending);
        case (state)
            ST_IDLE: begin
                if (sched_en && pending != '0) begin
                    grant                     = 1'b1;
                    grant_clr[type_bit(winner)] = 1'b1;
                    type_next                 = winner;
                    if (cfg_delay != '0) begin
                        state_next = ST_DELAY;
                        cnt_next   = CNT_W'(cfg_delay) - CNT_W'(1);
                    end else begin
                        state_next = ST_PULSE;
                        cnt_next   = (winner == PT_CAL) ? CAL_LAST : '0;
                    end
                end
            end
            ST_DELAY: begin
                if (cnt == '0) begin
                    state_next = ST_PULSE;
                    cnt_next   = (cur_type == PT_CAL) ? CAL_LAST : '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = HOLD_LAST;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                    type_next  = PT_NONE;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge bclk) begin
        if (!rstb) begin
            state    <= ST_IDLE;
            cur_type <= PT_NONE;
            cnt      <= '0;
        end else begin
            state    <= state_next;
            cur_type <= type_next;
            cnt      <= cnt_next;
        end
    end

    // Outputs are registered from the next state so each pulse is glitch-free.
    always_ff @(posedge bclk) begin
        if (!rstb) begin
            cal_pulse <= 1'b0;
            dtp_pulse <= 1'b0;
            hpr_clear <= 1'b0;
        end else begin
            cal_pulse <= (state_next == ST_PULSE) && (type_next == PT_CAL);
            dtp_pulse <= (state_next == ST_PULSE) && (type_next == PT_DTP);
            hpr_clear <= (state_next == ST_PULSE) && (type_next == PT_HPR);
        end
    end

    // The IDLE grant cycle already belongs to the sequence.
    assign busy = (state != ST_IDLE) || grant;

endmodule

// File: tb/tb_sc_pulse_sched.sv
// Directed self-checking bench for sc_pulse_sched.
// Honours SC_PERIODIC_HPR_EN when choosing the expected periodic behaviour.
module tb_sc_pulse_sched;

    logic        bclk = 1'b0;
    logic        rstb = 1'b0;
    logic        sched_en = 1'b0;
    logic [5:0]  cfg_delay = '0;
    logic [11:0] cfg_hpr_period = '0;
    logic        req_cal = 1'b0;
    logic        req_dtp = 1'b0;
    logic        req_hpr = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        cal_pulse, dtp_pulse, hpr_clear, busy;
    logic [2:0]  ovf;

    int checks = 0;
    int failures = 0;
    int hpr_count;
    int hpr_first;

    sc_pulse_sched dut (
        .bclk           (bclk),
        .rstb           (rstb),
        .sched_en       (sched_en),
        .cfg_delay      (cfg_delay),
        .cfg_hpr_period (cfg_hpr_period),
        .req_cal        (req_cal),
        .req_dtp        (req_dtp),
        .req_hpr        (req_hpr),
        .ovf_clr        (ovf_clr),
        .cal_pulse      (cal_pulse),
        .dtp_pulse      (dtp_pulse),
        .hpr_clear      (hpr_clear),
        .busy           (busy),
        .ovf            (ovf)
    );

    always #5 bclk = ~bclk;

    task automatic tick();
        @(posedge bclk);
        #2;
    endtask

    task automatic applyStimulus(input logic cal, input logic dtp, input logic hpr, input logic clr);
        req_cal = cal;
        req_dtp = dtp;
        req_hpr = hpr;
        ovf_clr = clr;
    endtask

    function automatic logic [31:0] outs();
        return {25'd0, busy, ovf, hpr_clear, dtp_pulse, cal_pulse};
    endfunction

    function automatic logic [31:0] ev(input bit b, input logic [2:0] o, input bit h, input bit d, input bit c);
        return {25'd0, b, o, h, d, c};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        // reset
        repeat (3) tick();
        rstb = 1'b1;
        tick();
        checkOutput("reset", outs(), ev(0, 3'b000, 0, 0, 0));

        // cal, zero delay
        $display("[TB] cal with zero delay");
        sched_en = 1'b1;
        tick();
        applyStimulus(1, 0, 0, 0);
        for (int c = 1; c <= 15; c++) begin
            tick();
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("cal_d0_c%0d", c), outs(),
                        ev(c >= 1 && c <= 13, 3'b000, 0, 0, c >= 2 && c <= 9));
        end

        // dtp, delay 5, cfg_delay changed after grant
        $display("[TB] dtp with delay 5");
        cfg_delay = 6'd5;
        tick();
        applyStimulus(0, 1, 0, 0);
        for (int c = 1; c <= 13; c++) begin
            tick();
            applyStimulus(0, 0, 0, 0);
            if (c == 2) cfg_delay = 6'd0;
            checkOutput($sformatf("dtp_d5_c%0d", c), outs(),
                        ev(c >= 1 && c <= 11, 3'b000, 0, c == 7, 0));
        end

        // simultaneous requests: hpr, cal, dtp
        $display("[TB] priority order");
        cfg_delay = 6'd0;
        tick();
        applyStimulus(1, 1, 1, 0);
        for (int c = 1; c <= 27; c++) begin
            tick();
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("prio_c%0d", c), outs(),
                        ev(c >= 1 && c <= 25, 3'b000, c == 2, c == 21, c >= 8 && c <= 15));
        end

        // overflow with scheduler disabled
        $display("[TB] overflow handling");
        sched_en = 1'b0;
        tick();
        applyStimulus(1, 0, 0, 0);
        tick();
        checkOutput("ovf_pending", outs(), ev(0, 3'b000, 0, 0, 0));
        applyStimulus(1, 0, 0, 0);
        tick();
        checkOutput("ovf_drop", outs(), ev(0, 3'b001, 0, 0, 0));
        applyStimulus(0, 0, 0, 1);
        tick();
        checkOutput("ovf_clr", outs(), ev(0, 3'b000, 0, 0, 0));
        applyStimulus(1, 0, 0, 1);
        tick();
        checkOutput("ovf_set_wins", outs(), ev(0, 3'b001, 0, 0, 0));
        applyStimulus(0, 0, 0, 1);
        tick();
        checkOutput("ovf_clr2", outs(), ev(0, 3'b000, 0, 0, 0));
        applyStimulus(0, 0, 0, 0);
        sched_en = 1'b1;
        for (int c = 6; c <= 20; c++) begin
            tick();
            checkOutput($sformatf("ovf_single_cal_c%0d", c), outs(),
                        ev(c <= 17, 3'b000, 0, 0, c <= 13));
        end

        // strobe in the grant cycle re-arms without overflow
        $display("[TB] re-arm on grant");
        tick();
        applyStimulus(1, 0, 0, 0);
        tick();
        checkOutput("rearm_c1", outs(), ev(1, 3'b000, 0, 0, 0));
        for (int c = 2; c <= 28; c++) begin
            tick();
            applyStimulus(0, 0, 0, 0);
            checkOutput($sformatf("rearm_c%0d", c), outs(),
                        ev(c <= 26, 3'b000, 0, 0, (c <= 9) || (c >= 15 && c <= 22)));
        end

        // reset during the 4th cal cycle, with a dtp waiting
        $display("[TB] mid-pulse reset");
        tick();
        applyStimulus(1, 0, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            applyStimulus(c == 2, 0, 0, 0);
            if (c == 2) applyStimulus(0, 1, 0, 0);
            checkOutput($sformatf("rst_pre_c%0d", c), outs(), ev(1, 3'b000, 0, 0, c >= 2));
        end
        rstb = 1'b0;
        tick();
        checkOutput("rst_abort", outs(), ev(0, 3'b000, 0, 0, 0));
        rstb = 1'b1;
        for (int c = 7; c <= 25; c++) begin
            tick();
            checkOutput($sformatf("rst_post_c%0d", c), outs(), ev(0, 3'b000, 0, 0, 0));
        end

        // periodic HPR clear
        $display("[TB] periodic hpr");
        tick();
        cfg_hpr_period = 12'd100;
        hpr_count = 0;
        hpr_first = 0;
        for (int c = 1; c <= 250; c++) begin
            tick();
            if (hpr_clear === 1'b1) begin
                if (hpr_count == 0) hpr_first = c;
                hpr_count++;
            end
        end
`ifdef SC_PERIODIC_HPR_EN
        checkOutput("period100_count", hpr_count, 2);
        checkOutput("period100_first", hpr_first, 101);
`else
        checkOutput("period100_count", hpr_count, 0);
        checkOutput("period100_first", hpr_first, 0);
`endif
        cfg_hpr_period = 12'd0;
        hpr_count = 0;
        for (int c = 1; c <= 250; c++) begin
            tick();
            if (hpr_clear === 1'b1) hpr_count++;
        end
        checkOutput("period0_count", hpr_count, 0);
        checkOutput("final_idle", outs(), ev(0, 3'b000, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sc_pulse_sched.md
Name: sc_pulse_sched

Overview:
Scheduler that sequences special-command pulses into the analogue and digital front end: calibration pulse, digital test pulse and hit-pattern-register (HPR) clear.
- Accepts one-cycle request strobes from the command decoder and, optionally, from an internal periodic HPR-clear timer.
- Arbitrates requests by fixed priority.
- Inserts a programmable trigger-to-pulse delay.
- Shapes each pulse to its required width, then enforces a holdoff before the next grant.
- Sits between the special-command register decode and the front-end pulse drivers.

Parameters:
DELAY_W, 6, width of cfg_delay (0..63 cycles of trigger-to-pulse delay)
CAL_WIDTH, 8, calibration pulse width in cycles (≥1)
HOLDOFF, 4, idle cycles enforced after every pulse (≥1)
PERIOD_W, 12, width of cfg_hpr_period

Ports:
bclk  in  1  bunch-crossing clock; the only clock
rstb  in  1  synchronous active-low reset
sched_en  in  1  1: grants allowed; 0: requests latch but are not granted
cfg_delay  in  DELAY_W  delay inserted before each pulse; sampled at grant
cfg_hpr_period  in  PERIOD_W  periodic HPR-clear interval; 0 disables it
req_cal  in  1  one-cycle calibration pulse request
req_dtp  in  1  one-cycle digital test pulse request
req_hpr  in  1  one-cycle HPR clear request
ovf_clr  in  1  clears the ovf sticky flags
cal_pulse  out  1  calibration pulse, CAL_WIDTH cycles
dtp_pulse  out  1  digital test pulse, 1 cycle
hpr_clear  out  1  HPR clear, 1 cycle
busy  out  1  high whenever state ≠ IDLE
ovf  out  3  sticky drop flags {hpr, dtp, cal}

Behaviour:
- One clock (bclk); synchronous active-low reset rstb.
- Reset:
  - state IDLE; pending bits, counters and all outputs 0; ovf 0.
  - Reset mid-operation aborts immediately: pulse outputs low on the next cycle, and pending requests are discarded.
- Pending latches, one per type:
  - A strobe sets its pending bit at the next edge.
  - A strobe arriving while that bit is already set drops the request and sets the matching ovf bit.
  - A strobe arriving in the same cycle its pending bit is cleared by a grant re-sets the bit (set wins; no ovf).
- ovf bits:
  - Cleared by ovf_clr.
  - If ovf_clr coincides with a new drop, the set wins.
- FSM states: IDLE, DELAY, PULSE, HOLD.
- IDLE:
  - If sched_en=1 and any bit is pending, grant by priority hpr > cal > dtp.
  - A grant clears the winner's pending bit, captures cfg_delay and records the pulse type.
  - Next state: DELAY if the captured delay ≠ 0, else PULSE, with the pulse output registered high from the next cycle.
- DELAY:
  - Counts down the captured delay.
  - Enters PULSE after exactly delay cycles, driving the type's output high.
- PULSE:
  - Output held for CAL_WIDTH cycles (cal) or 1 cycle (dtp, hpr).
  - Exactly one pulse output is high at any time.
- HOLD: HOLDOFF cycles with all pulse outputs low, then IDLE.
- Latency: strobe in cycle 0 with scheduler idle → pulse high from cycle 2+D, where D is the cfg_delay value sampled at grant.
- Back-to-back pulses: minimum spacing, from the falling edge of one pulse to the rising edge of the next, is HOLDOFF+1 cycles (the +1 is the IDLE grant cycle). Pulse outputs never run back-to-back.
- sched_en deasserted mid-operation: the current sequence completes; no new grant is made.
- Config changes: cfg_delay changes after grant do not affect the sequence in flight.
- Counters: all internal counters saturate/terminate exactly; no wrap-around glitches.

Optional Feature:
SC_PERIODIC_HPR_EN
- With the macro defined:
  - A free-running PERIOD_W counter is reset by rstb.
  - When cfg_hpr_period ≠ 0 and the counter reaches cfg_hpr_period−1, it issues an internal HPR request (ORed with req_hpr, same ovf rules) and reloads to 0.
  - cfg_hpr_period=0 holds the counter at 0.
- Without the macro: cfg_hpr_period is present but ignored; no counter is synthesised.

Decomposition:
Shared package sc_pkg holds:
- FSM state encoding (IDLE/DELAY/PULSE/HOLD).
- Pulse-type enum (NONE/CAL/DTP/HPR).
- Priority order constant.
- Default widths DELAY_W, CAL_WIDTH, HOLDOFF.

One natural sub-module: sc_req_latch, a per-type pending bit plus ovf sticky, instantiated three times.

Test Plan:
- Reset, then req_cal in cycle 0 with cfg_delay=0 → cal_pulse high cycles 2–9, busy high 1–13, ovf=0.
- cfg_delay=5, req_dtp in cycle 0 → dtp_pulse high only in cycle 7.
- req_cal, req_dtp and req_hpr all in the same cycle → hpr_clear first, then cal (8 cycles), then dtp. Each pulse rises HOLDOFF+1=5 cycles after the previous pulse falls.
- req_cal twice while still pending (sched_en=0) → ovf=3'b001. ovf_clr → ovf=0. sched_en=1 → exactly one cal pulse.
- rstb low during the 4th cal_pulse cycle → all outputs 0 next cycle; no pulse after release.
- With SC_PERIODIC_HPR_EN and cfg_hpr_period=100 → hpr_clear every 100 cycles. With cfg_hpr_period=0 → none. Without the macro → none regardless.
